// File: rtl/soma_pkg.sv
// rtl/soma_pkg.sv - shared widths and scan FSM state type for the soma scan controller
package soma_pkg;

  localparam int NNW_DEF = 12;
  localparam int VW_DEF  = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/soma_spk_fifo.sv
// rtl/soma_spk_fifo.sv - 2-entry spike address FIFO with registered head and occupancy count
module soma_spk_fifo #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [AW-1:0] i_push_data,
  input  logic          i_pop,
  output logic          o_head_vld,
  output logic [AW-1:0] o_head_data,
  output logic [1:0]    o_occ
);

  logic [AW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_occ;
  logic          w_pop;

  // Pop is qualified here so a stray ready on an empty FIFO cannot underflow.
  assign w_pop = i_pop & (r_occ != 2'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

  assign o_head_vld  = (r_occ != 2'd0);
  assign o_head_data = o_head_vld ? r_mem[r_rd_ptr] : '0;
  assign o_occ       = r_occ;

endmodule

// File: rtl/soma_scan_ctrl.sv
// rtl/soma_scan_ctrl.sv - per-timestep soma scan sequencer, spike buffer and host Vm arbiter
// Optional spike counter output enabled by SOMA_SCAN_SPKCNT_EN.
module soma_scan_ctrl
  import soma_pkg::*;
#(
  parameter int NNW       = NNW_DEF,
  parameter int VW        = VW_DEF,
  parameter int BUF_DEPTH = 2
) (
  input  logic           clk_soma,
  input  logic           rst_n,
  input  logic           tick_start,
  input  logic           tick_clear,
  input  logic [NNW-1:0] neuron_num,
  output logic           busy,
  output logic           done,
  output logic           soma_vld,
  output logic           soma_clear,
  output logic [NNW-1:0] soma_addr,
  input  logic           soma_fire,
  output logic           spk_vld,
  output logic [NNW-1:0] spk_addr,
  input  logic           spk_ready,
  input  logic           host_req,
  input  logic           host_we,
  input  logic [NNW-1:0] host_addr,
  input  logic [VW-1:0]  host_wdata,
  output logic           host_gnt,
  output logic           soma_vm_we,
  output logic           soma_vm_re,
  output logic [NNW-1:0] soma_vm_waddr,
  output logic [NNW-1:0] soma_vm_raddr,
  output logic [VW-1:0]  soma_vm_wdata,
  output logic           host_rdata_vld
`ifdef SOMA_SCAN_SPKCNT_EN
  ,
  output logic [NNW:0]   spk_cnt
`endif
);

  scan_state_e r_state;
  scan_state_e w_next;

  logic [NNW-1:0] r_n_lim;
  logic [NNW-1:0] r_addr;
  logic           r_mode_clr;
  logic           r_inflight;
  logic [NNW-1:0] r_infl_addr;
  logic           r_rd_pend;

  logic           w_tick;
  logic           w_accept;
  logic           w_issue;
  logic           w_issue_ok;
  logic           w_busy;
  logic           w_done;
  logic           w_push;
  logic           w_pop;
  logic [1:0]     w_occ;
  logic [2:0]     w_level;
  logic           w_host_win;
  logic           w_wr;
  logic           w_rd;

  assign w_tick = tick_start | tick_clear;
  assign w_pop  = spk_vld & spk_ready;
  assign w_push = r_inflight & soma_fire;

  // Projected buffer level counts the spike that may still land from the in-flight update.
  assign w_level    = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue_ok = r_mode_clr | (w_level < 3'(BUF_DEPTH));

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_issue  = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick) begin
          w_accept = 1'b1;
          w_next   = (neuron_num == '0) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        w_busy = 1'b1;
        if (w_issue_ok) begin
          w_issue = 1'b1;
          if (r_addr == r_n_lim - NNW'(1)) begin
            w_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        w_busy = 1'b1;
        if (!r_inflight && (w_occ == 2'd0)) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_soma) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_n_lim     <= '0;
      r_addr      <= '0;
      r_mode_clr  <= 1'b0;
      r_inflight  <= 1'b0;
      r_infl_addr <= '0;
      r_rd_pend   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_inflight  <= w_issue & ~r_mode_clr;
      r_infl_addr <= r_addr;
      r_rd_pend   <= w_rd;
      if (w_accept) begin
        r_n_lim    <= neuron_num;
        r_mode_clr <= tick_clear;
        r_addr     <= '0;
      end else if (w_issue) begin
        r_addr <= r_addr + NNW'(1);
      end
    end
  end

  soma_spk_fifo #(.AW(NNW)) u_spk_fifo (
    .clk         (clk_soma),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (r_infl_addr),
    .i_pop       (w_pop),
    .o_head_vld  (spk_vld),
    .o_head_data (spk_addr),
    .o_occ       (w_occ)
  );

  // Host owns the Vm port only while no scan write-back can be pending.
  assign w_host_win = rst_n & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign host_gnt   = host_req & w_host_win;
  assign w_wr       = host_gnt & host_we;
  assign w_rd       = host_gnt & ~host_we;

  assign soma_vm_we     = w_wr;
  assign soma_vm_waddr  = w_wr ? host_addr : '0;
  assign soma_vm_wdata  = w_wr ? host_wdata : '0;
  assign soma_vm_re     = w_rd;
  assign soma_vm_raddr  = w_rd ? host_addr : '0;
  assign host_rdata_vld = r_rd_pend;

  assign busy       = w_busy;
  assign done       = w_done;
  assign soma_vld   = w_issue;
  assign soma_clear = w_issue & r_mode_clr;
  assign soma_addr  = w_issue ? r_addr : '0;

`ifdef SOMA_SCAN_SPKCNT_EN
  logic [NNW:0] r_spk_cnt;

  always_ff @(posedge clk_soma) begin
    if (!rst_n) begin
      r_spk_cnt <= '0;
    end else if (w_accept) begin
      r_spk_cnt <= '0;
    end else if (w_push && (r_spk_cnt != '1)) begin
      r_spk_cnt <= r_spk_cnt + (NNW+1)'(1);
    end
  end

  assign spk_cnt = r_spk_cnt;
`endif

endmodule

// File: tb/tb_soma_scan_ctrl.sv
// tb/tb_soma_scan_ctrl.sv - randomized scoreboard bench for soma_scan_ctrl
module tb_soma_scan_ctrl;

  localparam int NNW = 12;
  localparam int VW  = 20;

  logic           clk_soma = 1'b0;
  logic           rst_n;
  logic           tick_start, tick_clear;
  logic [NNW-1:0] neuron_num;
  logic           busy, done, soma_vld, soma_clear;
  logic [NNW-1:0] soma_addr;
  logic           soma_fire;
  logic           spk_vld;
  logic [NNW-1:0] spk_addr;
  logic           spk_ready;
  logic           host_req, host_we;
  logic [NNW-1:0] host_addr;
  logic [VW-1:0]  host_wdata;
  logic           host_gnt, soma_vm_we, soma_vm_re, host_rdata_vld;
  logic [NNW-1:0] soma_vm_waddr, soma_vm_raddr;
  logic [VW-1:0]  soma_vm_wdata;
`ifdef SOMA_SCAN_SPKCNT_EN
  logic [NNW:0]   spk_cnt;
`endif

  soma_scan_ctrl dut (
    .clk_soma(clk_soma), .rst_n(rst_n),
    .tick_start(tick_start), .tick_clear(tick_clear), .neuron_num(neuron_num),
    .busy(busy), .done(done),
    .soma_vld(soma_vld), .soma_clear(soma_clear), .soma_addr(soma_addr), .soma_fire(soma_fire),
    .spk_vld(spk_vld), .spk_addr(spk_addr), .spk_ready(spk_ready),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .soma_vm_we(soma_vm_we), .soma_vm_re(soma_vm_re),
    .soma_vm_waddr(soma_vm_waddr), .soma_vm_raddr(soma_vm_raddr),
    .soma_vm_wdata(soma_vm_wdata), .host_rdata_vld(host_rdata_vld)
`ifdef SOMA_SCAN_SPKCNT_EN
    , .spk_cnt(spk_cnt)
`endif
  );

  initial forever #5 clk_soma = ~clk_soma;

  int errors = 0;
  int checks = 0;
  int exp_vld[$];
  int exp_spk[$];
  bit fire_pat[4096];
  int cyc = 0;
  int vld_cnt = 0;
  int first_vld = 0;
  int last_vld = 0;
  int done_cnt = 0;
  int scan_n = 0;
  bit chk_rate = 0;
  bit exp_done_pend = 0;
  int ready_mode = 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Soma model: fire flag follows an update strobe by one cycle; clear strobes also fire to prove they are ignored.
  initial begin
    bit nf;
    soma_fire = 1'b0;
    forever begin
      @(negedge clk_soma);
      nf = soma_vld && (soma_clear || fire_pat[soma_addr]);
      @(posedge clk_soma);
      #1 soma_fire = nf;
    end
  end

  initial begin
    spk_ready = 1'b0;
    forever begin
      @(posedge clk_soma);
      #1 spk_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(ready_mode);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a strobe, spike or done.
  initial begin
    int e;
    forever begin
      @(negedge clk_soma);
      cyc++;
      if (rst_n) begin
        if (soma_vld) begin
          vld_cnt++;
          if (vld_cnt == 1) first_vld = cyc;
          last_vld = cyc;
          if (exp_vld.size() == 0) chk("vld_unexpected", 1, 0);
          else begin
            e = exp_vld.pop_front();
            chk("soma_addr", int'(soma_addr), e & 'hfff);
            chk("soma_clear", int'(soma_clear), e >> 12);
          end
        end
        if (spk_vld && exp_spk.size() == 0) chk("spk_unexpected", 1, 0);
        else if (spk_vld && spk_ready) begin
          e = exp_spk.pop_front();
          chk("spk_addr", int'(spk_addr), e);
        end
        if (done) begin
          done_cnt++;
          chk("busy_on_done", int'(busy), 0);
          chk("done_expected", int'(exp_done_pend), 1);
          exp_done_pend = 0;
          chk("vld_left", exp_vld.size(), 0);
          chk("spk_left", exp_spk.size(), 0);
          if (chk_rate && scan_n > 0) chk("vld_span", last_vld - first_vld, scan_n - 1);
        end
      end
    end
  end

  task automatic do_tick(int n, bit clr, bit both, bit rate);
    @(posedge clk_soma);
    #1;
    scan_n = n;
    chk_rate = rate;
    vld_cnt = 0;
    for (int a = 0; a < n; a++) begin
      exp_vld.push_back((int'(clr) << 12) | a);
      if (!clr && fire_pat[a]) exp_spk.push_back(a);
    end
    exp_done_pend = 1;
    tick_clear = clr;
    tick_start = !clr || both;
    neuron_num = NNW'(n);
    @(posedge clk_soma);
    #1;
    tick_start = 1'b0;
    tick_clear = 1'b0;
    neuron_num = NNW'($urandom_range(0, 4095));
  endtask

  task automatic wait_done(int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_soma);
      if (done_cnt != d0) break;
    end
    chk("done_timeout", int'(done_cnt != d0), 1);
  endtask

  task automatic set_fire(int mode);
    for (int a = 0; a < 4096; a++)
      fire_pat[a] = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_soma_vld"}, int'(soma_vld), 0);
    chk({tag, "_soma_addr"}, int'(soma_addr), 0);
    chk({tag, "_spk_vld"}, int'(spk_vld), 0);
    chk({tag, "_spk_addr"}, int'(spk_addr), 0);
    chk({tag, "_vm_we"}, int'(soma_vm_we), 0);
    chk({tag, "_rdata_vld"}, int'(host_rdata_vld), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    int d0;
    logic [NNW-1:0] ha;
    logic [VW-1:0] hd;
    rst_n = 1'b0;
    tick_start = 1'b0; tick_clear = 1'b0; neuron_num = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    set_fire(0);
    repeat (3) @(posedge clk_soma);
    @(negedge clk_soma);
    chk_idle_outputs("reset");
    chk("reset_gnt", int'(host_gnt), 0);
    @(posedge clk_soma);
    #1 rst_n = 1'b1;

    // Directed: 4 neurons, fires at 1 and 3, full throughput.
    set_fire(0);
    fire_pat[1] = 1'b1;
    fire_pat[3] = 1'b1;
    ready_mode = 1;
    do_tick(4, 0, 0, 1);
    wait_done(50);

    // Backpressure: all fire, ready low -> only two issues fit.
    set_fire(1);
    ready_mode = 0;
    do_tick(8, 0, 0, 0);
    repeat (20) @(posedge clk_soma);
    @(negedge clk_soma);
    chk("stall_issues", vld_cnt, 2);
    chk("stall_busy", int'(busy), 1);
    ready_mode = 1;
    wait_done(100);

    // Clear scan, coincident with start; fire ignored.
    set_fire(1);
    do_tick(3, 1, 1, 1);
    wait_done(50);

    // Zero neurons: done right after tick, no strobes.
    d0 = done_cnt;
    do_tick(0, 0, 0, 0);
    repeat (2) @(negedge clk_soma);
    #1 chk("zero_done", done_cnt - d0, 1);

    // Host write held during a scan, then a read.
    set_fire(2);
    ready_mode = 2;
    do_tick(6, 0, 0, 0);
    ha = NNW'($urandom_range(0, 4095));
    hd = VW'($urandom);
    host_req = 1'b1; host_we = 1'b1; host_addr = ha; host_wdata = hd;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_soma);
      if (host_gnt) begin hit = 1; break; end
      if (busy) chk("gnt_in_scan", int'(soma_vm_we), 0);
    end
    chk("host_gnt_seen", int'(hit), 1);
    chk("gnt_busy", int'(busy), 0);
    chk("vm_we", int'(soma_vm_we), 1);
    chk("vm_waddr", int'(soma_vm_waddr), int'(ha));
    chk("vm_wdata", int'(soma_vm_wdata), int'(hd));
    @(posedge clk_soma);
    #1 host_we = 1'b0; ha = NNW'($urandom_range(0, 4095)); host_addr = ha;
    @(negedge clk_soma);
    chk("rd_gnt", int'(host_gnt), 1);
    chk("vm_re", int'(soma_vm_re), 1);
    chk("vm_raddr", int'(soma_vm_raddr), int'(ha));
    chk("rdata_vld_early", int'(host_rdata_vld), 0);
    @(posedge clk_soma);
    #1 host_req = 1'b0;
    @(negedge clk_soma);
    chk("rdata_vld", int'(host_rdata_vld), 1);
    @(negedge clk_soma);
    chk("rdata_vld_once", int'(host_rdata_vld), 0);

    // Reset mid-scan with the spike buffer full.
    set_fire(1);
    ready_mode = 0;
    do_tick(8, 0, 0, 0);
    repeat (6) @(posedge clk_soma);
    #1 rst_n = 1'b0;
    @(posedge clk_soma);
    #1;
    exp_vld.delete();
    exp_spk.delete();
    exp_done_pend = 0;
    @(negedge clk_soma);
    chk_idle_outputs("midrst");
    @(posedge clk_soma);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk_soma);
    set_fire(2);
    ready_mode = 1;
    do_tick(5, 0, 0, 1);
    wait_done(50);

    // Random scans with random backpressure.
    ready_mode = 2;
    for (int k = 0; k < 12; k++) begin
      set_fire(2);
      do_tick($urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      wait_done(400);
    end

    // Largest scan: addresses 0..4094, no wrap.
    set_fire(2);
    ready_mode = 1;
    do_tick(4095, 0, 0, 1);
    wait_done(5000);

    repeat (3) @(posedge clk_soma);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
